// File: rtl/conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv_sequencer
// Description : Streams an IMG_W x IMG_H image out of a 1-cycle-latency ROM in
//               raster order, loads each pixel into a 3x3 window shifter and
//               flags every position where a full window is present.
//
//               Ports
//                 clk        rising-edge clock
//                 rst        synchronous active-high reset
//                 start      frame request pulse (accepted only in IDLE)
//                 out_ready  downstream accepts the current window result
//                 rom_en     ROM read strobe
//                 rom_addr   raster-order pixel address
//                 shift_en   window shift-register load enable
//                 out_valid  a full 3x3 window is present
//                 busy       high in RUN and DRAIN
//                 done       one-cycle pulse at frame end
//
//               Optional feature macro: SEQ_BACKPRESSURE_EN
//                 defined   : out_ready can stall the pipeline
//                 undefined : out_ready is ignored, frame time is fixed
// Revision    : 1.0 - initial release
// ============================================================================
module conv_sequencer #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              out_ready,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              shift_en,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam int C_COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    // One extra code so the row counter can step past the last row cleanly
    localparam int C_ROW_W = $clog2(IMG_H + 1);

    localparam logic [ADDR_W-1:0]  C_LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [C_COL_W-1:0] C_COL_LAST  = C_COL_W'(IMG_W - 1);
    localparam logic [C_COL_W-1:0] C_COL_TWO   = C_COL_W'(2);
    localparam logic [C_ROW_W-1:0] C_ROW_TWO   = C_ROW_W'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [C_COL_W-1:0]  r_col;
    logic [C_ROW_W-1:0]  r_row;
    logic                r_pending;
    logic                r_out_valid;
    logic                r_busy;
    logic                r_done;

    logic                w_ready_eff;
    logic                w_stall;
    logic                w_rom_en;
    logic                w_shift_en;
    logic                w_win;

`ifdef SEQ_BACKPRESSURE_EN
    assign w_ready_eff = out_ready;
`else
    // Downstream is assumed to always take the result; out_ready has no effect
    logic w_unused_ready;
    assign w_unused_ready = out_ready;
    assign w_ready_eff    = 1'b1;
`endif

    // A result that is presented but not taken freezes the whole pipeline
    assign w_stall    = r_out_valid & ~w_ready_eff;
    assign w_rom_en   = (r_state == S_RUN) & ~w_stall;
    // The ROM holds its data while rom_en is low, so a pending pixel can wait
    assign w_shift_en = r_pending & ~w_stall;
    // Pixel being shifted closes a 3x3 window once two rows and two columns precede it
    assign w_win      = (r_col >= C_COL_TWO) & (r_row >= C_ROW_TWO);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_pending   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Read issued this cycle becomes the pixel to shift next cycle
            r_pending <= w_rom_en | (r_pending & ~w_shift_en);

            if (w_shift_en) begin
                if (r_col == C_COL_LAST) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            if (w_shift_en && w_win) begin
                r_out_valid <= 1'b1;
            end else if (w_ready_eff) begin
                r_out_valid <= 1'b0;
            end

            // Address parks on the last pixel instead of wrapping
            if (w_rom_en && (r_addr != C_LAST_ADDR)) begin
                r_addr <= r_addr + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state     <= S_RUN;
                        r_busy      <= 1'b1;
                        r_addr      <= '0;
                        r_col       <= '0;
                        r_row       <= '0;
                        r_pending   <= 1'b0;
                        r_out_valid <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_rom_en && (r_addr == C_LAST_ADDR)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!r_pending && (!r_out_valid || w_ready_eff)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    // start is deliberately not looked at here
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are forced low for the whole time reset is held
    assign rom_en    = w_rom_en & ~rst;
    assign rom_addr  = rst ? '0 : r_addr;
    assign shift_en  = w_shift_en & ~rst;
    assign out_valid = r_out_valid & ~rst;
    assign busy      = r_busy & ~rst;
    assign done      = r_done & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_sequencer
// Description : Self-checking bench for conv_sequencer. A scoreboard records
//               each issued read and each window-closing shift and retires
//               them against the DUT strobes; directed frames cover reset,
//               start filtering, mid-frame abort and the out_ready behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_sequencer;

    localparam int W     = 32;
    localparam int H     = 32;
    localparam int AW    = 10;
    localparam int N     = W * H;
    localparam int BEATS = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;
    logic          rom_en, shift_en, out_valid, busy, done;
    logic [AW-1:0] rom_addr;

    logic          start4 = 1'b0;
    logic          out_ready4 = 1'b1;
    logic          rom_en4, shift_en4, out_valid4, busy4, done4;
    logic [3:0]    rom_addr4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    conv_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .out_ready(out_ready),
        .rom_en(rom_en), .rom_addr(rom_addr), .shift_en(shift_en),
        .out_valid(out_valid), .busy(busy), .done(done)
    );

    conv_sequencer #(.IMG_W(4), .IMG_H(4), .ADDR_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .out_ready(out_ready4),
        .rom_en(rom_en4), .rom_addr(rom_addr4), .shift_en(shift_en4),
        .out_valid(out_valid4), .busy(busy4), .done(done4)
    );

`ifdef SEQ_BACKPRESSURE_EN
    wire ready_eff = out_ready;
`else
    wire ready_eff = 1'b1;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // ---------------- scoreboard for the 32x32 DUT ----------------
    bit mon_en = 1'b0;
    int cyc = 0, exp_addr = 0, reads = 0, beats = 0, done_cnt = 0;
    int rd_q[$];
    int win_q[$];
    bit last_win, last_ov, last_acc, first_win_seen, m_win;
    int m_a;

    task automatic clear_model();
        rd_q.delete();
        win_q.delete();
        exp_addr = 0; reads = 0; beats = 0; done_cnt = 0;
        last_win = 0; last_ov = 0; last_acc = 0; first_win_seen = 0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (done) done_cnt++;
        if (mon_en) begin
            m_win = 1'b0;
            // Shift consumes the read issued on an earlier cycle
            if (shift_en) begin
                if (rd_q.size() == 0) begin
                    chk("shift_without_read", 1, 0);
                end else begin
                    m_a = rd_q.pop_front();
                    if ((m_a % W) >= 2 && (m_a / W) >= 2) begin
                        m_win = 1'b1;
                        win_q.push_back(m_a);
                        first_win_seen = 1'b1;
                    end
                end
            end
            if (rom_en) begin
                chk("rom_addr", 32'(rom_addr), exp_addr);
                rd_q.push_back(exp_addr);
                exp_addr++;
                reads++;
            end
            chk("out_valid", 32'(out_valid), 32'(last_win | (last_ov & ~last_acc)));
            if (out_valid && ready_eff) begin
                beats++;
                if (win_q.size() == 0) chk("beat_without_window", 1, 0);
                else void'(win_q.pop_front());
            end
            last_win = m_win;
            last_ov  = out_valid;
            last_acc = ready_eff;
        end
    end

    // ---------------- window capture for the 4x4 DUT ----------------
    int rd4 = 0, sh4_prev = 0;
    bit sh4_prev_v = 0;
    int q4[$];
    always @(negedge clk) begin
        if (out_valid4) q4.push_back(sh4_prev_v ? sh4_prev : -1);
        sh4_prev_v = shift_en4;
        if (shift_en4) sh4_prev = rd4;
        if (rom_en4) rd4 = 32'(rom_addr4);
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rom_en"},    32'(rom_en),    0);
        chk({tag, "_rom_addr"},  32'(rom_addr),  0);
        chk({tag, "_shift_en"},  32'(shift_en),  0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_busy"},      32'(busy),      0);
        chk({tag, "_done"},      32'(done),      0);
    endtask

    bit kick4 = 1'b0;

    // Runs one full frame; expected length counts the start cycle, N reads,
    // two drain cycles, the done cycle, plus any injected stall cycles.
    task automatic run_frame(input bit mid_pulse, input bit done_pulse,
                             input bit do_stall, output int len);
        int  s;
        bit  got;
        bit  stalled;
        clear_model();
        mon_en  = 1'b1;
        got     = 1'b0;
        stalled = 1'b0;
        @(posedge clk); #1; start = 1'b1; start4 = kick4; s = cyc;
        @(posedge clk); #1; start = 1'b0; start4 = 1'b0;
        for (int i = 0; i < 3 * N; i++) begin
            @(negedge clk); #1;
            if (i == 0) chk("busy_in_run", 32'(busy), 1);
            start = mid_pulse && (i == 300);
            if (done) begin
                got = 1'b1;
                break;
            end
`ifdef SEQ_BACKPRESSURE_EN
            if (do_stall && first_win_seen && !stalled) begin
                stalled = 1'b1;
                @(posedge clk); #1; out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk); #1;
                    chk("stall_rom_en",    32'(rom_en),    0);
                    chk("stall_shift_en",  32'(shift_en),  0);
                    chk("stall_out_valid", 32'(out_valid), 1);
                    chk("stall_rom_addr",  32'(rom_addr),  exp_addr);
                end
                @(posedge clk); #1; out_ready = 1'b1;
            end
`endif
        end
        start = 1'b0;
        if (!got) chk("done_timeout", 0, 1);
        len = cyc - s;
        if (done_pulse) begin
            start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
        end
        @(negedge clk); #1;
        chk("busy_after_done",   32'(busy),   0);
        chk("done_single_cycle", 32'(done),   0);
        chk("idle_after_done",   32'(rom_en), 0);
        mon_en = 1'b0;
        chk("frame_reads",  reads,           N);
        chk("frame_beats",  beats,           BEATS);
        chk("done_pulses",  done_cnt,        1);
        chk("windows_left", win_q.size(),    0);
        chk("reads_left",   rd_q.size(),     0);
`ifdef SEQ_BACKPRESSURE_EN
        chk("frame_len", len, N + 4 + (do_stall ? 5 : 0));
`else
        chk("frame_len", len, N + 4);
`endif
    endtask

    int  len_a, len_b;
    bit  got500;
    int  exp4[4] = '{10, 11, 14, 15};

    initial begin
        // Reset state, checked while rst is still asserted
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk_idle_outputs("in_reset");
        rst = 1'b0;
        @(negedge clk); #1;
        chk_idle_outputs("after_reset");

        // Plain frame with the 4x4 instance running alongside
        kick4 = 1'b1;
        run_frame(1'b0, 1'b0, 1'b0, len_a);
        kick4 = 1'b0;
        chk("w4_beats", q4.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q4.size()) chk("w4_window_addr", q4[i], exp4[i]);
        end

        // start during RUN and during DONE is ignored
        run_frame(1'b1, 1'b1, 1'b0, len_b);
        chk("len_with_stray_starts", len_b, len_a);

        // Abort at address 500
        clear_model();
        mon_en = 1'b1;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        got500 = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk); #1;
            if (rom_en && rom_addr == AW'(500)) begin
                got500 = 1'b1;
                break;
            end
        end
        chk("reach_addr_500", 32'(got500), 1);
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk); #1;
        chk_idle_outputs("abort_reset");
        rst = 1'b0;
        @(negedge clk); #1;
        chk_idle_outputs("abort_release");
        repeat (5) @(negedge clk);
        #1;
        chk("no_done_on_abort", done_cnt, 0);

        // Restart after abort begins at address 0
        run_frame(1'b0, 1'b0, 1'b0, len_b);

`ifdef SEQ_BACKPRESSURE_EN
        run_frame(1'b0, 1'b0, 1'b1, len_b);
        chk("len_with_stall", len_b, len_a + 5);
`else
        out_ready = 1'b0;
        run_frame(1'b0, 1'b0, 1'b0, len_b);
        out_ready = 1'b1;
        chk("len_ready_low", len_b, len_a);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
